// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Optional feature macro: LEADING_BLANK_EN (adds the BLANK output).
package bin2bcd_pkg;

    localparam int BCD_W = 4;

    typedef enum logic {
        IDLE,
        SUB
    } state_t;

    function automatic int unsigned pow10(input int unsigned k);
        int unsigned p;
        p = 1;
        for (int unsigned i = 0; i < k; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/done handshake bundle between a client and bin2bcd_seq.
// Optional feature macro: LEADING_BLANK_EN (adds BLANK to the bundle).
interface bin2bcd_seq_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  START;
    logic [WIDTH-1:0]      D;
    logic                  BUSY;
    logic                  DONE;
    logic [4*DIGITS-1:0]   BCD;
`ifdef LEADING_BLANK_EN
    logic [DIGITS-1:0]     BLANK;

    modport master (
        output START, D,
        input  BUSY, DONE, BCD, BLANK
    );
    modport slave (
        input  START, D,
        output BUSY, DONE, BCD, BLANK
    );
`else
    modport master (
        output START, D,
        input  BUSY, DONE, BCD
    );
    modport slave (
        input  START, D,
        output BUSY, DONE, BCD
    );
`endif
endinterface

// File: rtl/bin2bcd_seq_sub_cmp.sv
// Combinational subtract-compare: a-b with the borrow reused as the a>=b test.
module sub_cmp #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             ge
);
    logic borrow;

    assign {borrow, diff} = {1'b0, a} - {1'b0, b};
    assign ge = ~borrow;
endmodule

// File: rtl/bin2bcd_seq.sv
// Binary-to-BCD by repeated subtraction of powers of ten, one step per cycle.
// Optional feature macro: LEADING_BLANK_EN (registered leading-zero blank mask).
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input logic         CLK,
    input logic         CLR_N,
    bin2bcd_seq_if.slave bus
);
    localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [KW-1:0] KINIT = KW'(DIGITS - 1);
    localparam int unsigned MAXV = (32'd1 << WIDTH) - 32'd1;

    if (WIDTH < 1 || WIDTH > 16 || DIGITS < 2 ||
        !(MAXV < pow10(DIGITS))) begin : g_bad_cfg
        $error("bin2bcd_seq: DIGITS too small for WIDTH");
    end

    typedef logic [DIGITS-1:0][BCD_W-1:0] digs_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    digs_t            dig_q, dig_d;
    logic [KW-1:0]    k_q, k_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    digs_t            bcd_q, bcd_d;

    // Powers of ten beyond the operand range can never be subtracted.
    logic [DIGITS-1:0][WIDTH-1:0] pk;
    logic [DIGITS-1:0]            ov;

    for (genvar i = 0; i < DIGITS; i++) begin : g_pow
        localparam int unsigned PV = pow10(i);
        assign pk[i] = PV[WIDTH-1:0];
        assign ov[i] = (PV > MAXV);
    end

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] diff;
    logic             cmp_ge;
    logic             ge;
    logic [3:0]       r_lo;
    digs_t            fin;

    assign p  = pk[k_q];
    assign ge = cmp_ge & ~ov[k_q];

    sub_cmp #(.WIDTH(WIDTH)) u_cmp (
        .a    (r_q),
        .b    (p),
        .diff (diff),
        .ge   (cmp_ge)
    );

    if (WIDTH >= 4) begin : g_lo_w
        assign r_lo = r_q[3:0];
    end else begin : g_lo_n
        assign r_lo = {{(4-WIDTH){1'b0}}, r_q};
    end

    always_comb begin
        fin    = dig_q;
        fin[0] = r_lo;
    end

`ifdef LEADING_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;
    logic [DIGITS-1:0] blank_n;

    always_comb begin
        logic z;
        z          = 1'b1;
        blank_n    = '0;
        for (int j = DIGITS - 1; j >= 1; j--) begin
            z          = z & (fin[j] == 4'd0);
            blank_n[j] = z;
        end
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_d;
        end
    end

    always_comb begin
        blank_d = blank_q;
        if (state_q == SUB && !ge && k_q <= KW'(1)) begin
            blank_d = blank_n;
        end
    end

    assign bus.BLANK = blank_q;
`endif

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q <= IDLE;
            r_q     <= '0;
            dig_q   <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            dig_q   <= dig_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        dig_d   = dig_q;
        k_d     = k_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bcd_d   = bcd_q;
        unique case (state_q)
            IDLE: begin
                if (bus.START) begin
                    r_d     = bus.D;
                    dig_d   = '0;
                    k_d     = KINIT;
                    busy_d  = 1'b1;
                    state_d = SUB;
                end
            end
            SUB: begin
                if (ge) begin
                    r_d        = diff;
                    dig_d[k_q] = dig_q[k_q] + 4'd1;
                end else if (k_q > KW'(1)) begin
                    k_d = k_q - 1'b1;
                end else begin
                    dig_d   = fin;
                    bcd_d   = fin;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
    assign bus.BCD  = bcd_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomized self-checking bench for bin2bcd_seq against a decimal reference model.
// Optional feature macro: LEADING_BLANK_EN (adds blank-mask checks).
module tb_bin2bcd_seq;
    logic CLK;
    logic CLR_N;
    int   asserts;
    int   fails;

    bin2bcd_seq_if #(.WIDTH(8), .DIGITS(3)) bus ();

    bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
        .CLK   (CLK),
        .CLR_N (CLR_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [11:0] ref_bcd(input int v);
        logic [3:0] h, t, o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    function automatic int ref_lat(input int v);
        return 1 + (v / 100) + ((v / 10) % 10) + 2;
    endfunction

    function automatic logic [2:0] ref_blank(input int v);
        logic [2:0] b;
        b    = 3'b000;
        b[2] = (v < 100);
        b[1] = (v < 10);
        return b;
    endfunction

    // Issues one request and waits for DONE; no checking here.
    task automatic run_one(input int d, output int lat, output int busy_cnt,
                           output bit to);
        @(negedge CLK);
        bus.START = 1'b1;
        bus.D     = 8'(d);
        @(posedge CLK);
        #1;
        bus.START = 1'b0;
        bus.D     = 8'($urandom);
        lat       = 1;
        busy_cnt  = 0;
        while (!bus.DONE && lat < 40) begin
            if (bus.BUSY) busy_cnt++;
            @(posedge CLK);
            #1;
            lat++;
        end
        to = !bus.DONE;
    endtask

    task automatic test_reset();
        CLR_N     = 1'b0;
        bus.START = 1'b0;
        bus.D     = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        asserts++;
        if ({bus.BUSY, bus.DONE, bus.BCD} !== 14'd0) begin
            fails++;
            $display("FAIL reset: busy=%b done=%b bcd=%h want 0 0 000",
                     bus.BUSY, bus.DONE, bus.BCD);
        end
`ifdef LEADING_BLANK_EN
        asserts++;
        if (bus.BLANK !== 3'b000) begin
            fails++;
            $display("FAIL reset_blank: got %b want 000", bus.BLANK);
        end
`endif
        CLR_N = 1'b1;
    endtask

    task automatic test_convert(input int d, input string nm);
        int lat, bc;
        bit to;
        run_one(d, lat, bc, to);
        asserts++;
        if (to) begin
            fails++;
            $display("FAIL %s_timeout: no DONE for D=%0d", nm, d);
            return;
        end
        asserts++;
        if (bus.BCD !== ref_bcd(d)) begin
            fails++;
            $display("FAIL %s_bcd: D=%0d got %h want %h", nm, d, bus.BCD, ref_bcd(d));
        end
        asserts++;
        if (lat !== ref_lat(d)) begin
            fails++;
            $display("FAIL %s_lat: D=%0d got %0d want %0d", nm, d, lat, ref_lat(d));
        end
        asserts++;
        if (bc !== ref_lat(d) - 1 || bus.BUSY !== 1'b0) begin
            fails++;
            $display("FAIL %s_busy: D=%0d busy cycles %0d want %0d, busy@done=%b",
                     nm, d, bc, ref_lat(d) - 1, bus.BUSY);
        end
`ifdef LEADING_BLANK_EN
        asserts++;
        if (bus.BLANK !== ref_blank(d)) begin
            fails++;
            $display("FAIL %s_blank: D=%0d got %b want %b", nm, d, bus.BLANK, ref_blank(d));
        end
`endif
        @(posedge CLK);
        #1;
        asserts++;
        if (bus.DONE !== 1'b0 || bus.BCD !== ref_bcd(d)) begin
            fails++;
            $display("FAIL %s_hold: done=%b bcd=%h want 0 %h", nm, bus.DONE, bus.BCD,
                     ref_bcd(d));
        end
    endtask

    task automatic test_vectors();
        test_convert(255, "d255");
        test_convert(0, "d0");
        test_convert(100, "d100");
    endtask

    task automatic test_ignore_busy();
        int dones;
        logic [11:0] last;
        dones = 0;
        last  = '0;
        @(negedge CLK);
        bus.START = 1'b1;
        bus.D     = 8'd42;
        @(negedge CLK);
        bus.START = 1'b0;
        @(negedge CLK);
        bus.START = 1'b1;
        bus.D     = 8'd200;
        @(negedge CLK);
        bus.START = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge CLK);
            #1;
            if (bus.DONE) begin
                dones++;
                last = bus.BCD;
            end
        end
        asserts++;
        if (dones !== 1 || last !== 12'h042) begin
            fails++;
            $display("FAIL ignore_busy: dones=%0d bcd=%h want 1 042", dones, last);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge CLK);
        bus.START = 1'b1;
        bus.D     = 8'd199;
        @(negedge CLK);
        bus.START = 1'b0;
        repeat (3) @(negedge CLK);
        #2;
        CLR_N = 1'b0;
        #1;
        asserts++;
        if ({bus.BUSY, bus.DONE, bus.BCD} !== 14'd0) begin
            fails++;
            $display("FAIL reset_mid: busy=%b done=%b bcd=%h want 0 0 000",
                     bus.BUSY, bus.DONE, bus.BCD);
        end
        @(negedge CLK);
        CLR_N = 1'b1;
        test_convert(7, "after_reset");
    endtask

    task automatic test_back_to_back();
        int ds[3];
        logic [11:0] got[$];
        int idx, extra;
        ds    = '{9, 10, 99};
        idx   = 0;
        extra = 0;
        @(negedge CLK);
        bus.START = 1'b1;
        bus.D     = 8'(ds[0]);
        for (int c = 0; c < 80 && idx < 3; c++) begin
            @(posedge CLK);
            #1;
            if (bus.DONE) begin
                got.push_back(bus.BCD);
                idx++;
                if (idx < 3) bus.D = 8'(ds[idx]);
                else bus.START = 1'b0;
            end
        end
        bus.START = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge CLK);
            #1;
            if (bus.DONE) extra++;
        end
        asserts++;
        if (got.size() !== 3 || extra !== 0) begin
            fails++;
            $display("FAIL b2b_count: got %0d results + %0d extra want 3 + 0",
                     got.size(), extra);
        end
        for (int i = 0; i < got.size() && i < 3; i++) begin
            asserts++;
            if (got[i] !== ref_bcd(ds[i])) begin
                fails++;
                $display("FAIL b2b_%0d: got %h want %h", i, got[i], ref_bcd(ds[i]));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            test_convert(int'($urandom_range(0, 255)), "rand");
        end
    endtask

`ifdef LEADING_BLANK_EN
    task automatic test_blank();
        test_convert(7, "blank7");
        test_convert(0, "blank0");
        test_convert(105, "blank105");
        test_convert(30, "blank30");
    endtask
`endif

    initial begin
        asserts = 0;
        fails   = 0;
        test_reset();
        test_vectors();
        test_ignore_busy();
        test_reset_mid();
        test_back_to_back();
        test_random();
`ifdef LEADING_BLANK_EN
        test_blank();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
